// File: rtl/packet_tx_framer.sv
// rtl/packet_tx_framer.sv - frames upstream packet beats into a sync/header/payload UART byte stream
// Optional feature: define PACKET_CHECKSUM_EN to append a mod-256 checksum byte to every frame.
package packet_tx_framer_pkg;
  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;
endpackage

module packet_tx_framer
  import packet_tx_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'h55
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  UART_PACKET ipTxStream,
  output logic       opTxReady,
  output logic [7:0] opUartData,
  output logic       opUartValid,
  input  logic       ipUartReady
);

`ifdef PACKET_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, DEST, SRC, LEN, PAYLOAD, DROP, CSUM} tState;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DEST, SRC, LEN, PAYLOAD, DROP} tState;
`endif

  tState      state;
  tState      nextState;
  tState      endState;
  logic [7:0] destReg;
  logic [7:0] srcReg;
  logic [7:0] lenReg;
  logic [7:0] dataReg;
  logic [7:0] count;
  logic       dataFull;
  logic       eopSeen;
  logic       readyEn;
  logic       txReadyRaw;
  logic       beatFire;
  logic       uartFire;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0] sumReg;
`endif

  // readyEn keeps opTxReady low until the first edge after reset is released
  always_comb begin
    txReadyRaw = 1'b0;
    case (state)
      IDLE:    txReadyRaw = 1'b1;
      DROP:    txReadyRaw = 1'b1;
      PAYLOAD: txReadyRaw = !eopSeen && (!dataFull || (ipUartReady && count > 8'd1));
      default: txReadyRaw = 1'b0;
    endcase
  end

  assign opTxReady = readyEn && txReadyRaw;
  assign beatFire  = ipTxStream.Valid && opTxReady;
  assign uartFire  = opUartValid && ipUartReady;

  always_comb begin
`ifdef PACKET_CHECKSUM_EN
    endState = CSUM;
`else
    endState = eopSeen ? IDLE : DROP;
`endif
  end

  always_comb begin
    nextState   = state;
    opUartValid = 1'b0;
    opUartData  = 8'h00;
    case (state)
      IDLE: if (beatFire && ipTxStream.SoP) nextState = SYNC;
      SYNC: begin
        opUartValid = 1'b1;
        opUartData  = SYNC_BYTE;
        if (ipUartReady) nextState = DEST;
      end
      DEST: begin
        opUartValid = 1'b1;
        opUartData  = destReg;
        if (ipUartReady) nextState = SRC;
      end
      SRC: begin
        opUartValid = 1'b1;
        opUartData  = srcReg;
        if (ipUartReady) nextState = LEN;
      end
      LEN: begin
        opUartValid = 1'b1;
        opUartData  = lenReg;
        if (ipUartReady) nextState = (lenReg == 8'd0) ? endState : PAYLOAD;
      end
      // once EoP has been taken, any shortfall in the payload is padded with zeros
      PAYLOAD: begin
        opUartValid = dataFull || eopSeen;
        opUartData  = dataFull ? dataReg : 8'h00;
        if (opUartValid && ipUartReady && count == 8'd1) nextState = endState;
      end
      DROP: if (beatFire && ipTxStream.EoP) nextState = IDLE;
`ifdef PACKET_CHECKSUM_EN
      CSUM: begin
        opUartValid = 1'b1;
        opUartData  = sumReg;
        if (ipUartReady) nextState = eopSeen ? IDLE : DROP;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state    <= IDLE;
      readyEn  <= 1'b0;
      destReg  <= 8'h00;
      srcReg   <= 8'h00;
      lenReg   <= 8'h00;
      dataReg  <= 8'h00;
      count    <= 8'h00;
      dataFull <= 1'b0;
      eopSeen  <= 1'b0;
    end else begin
      state   <= nextState;
      readyEn <= 1'b1;
      if (state == IDLE && beatFire && ipTxStream.SoP) begin
        destReg  <= ipTxStream.Destination;
        srcReg   <= ipTxStream.Source;
        lenReg   <= ipTxStream.Length;
        dataReg  <= ipTxStream.Data;
        count    <= ipTxStream.Length;
        dataFull <= (ipTxStream.Length != 8'd0);
        eopSeen  <= ipTxStream.EoP;
      end else if (state == PAYLOAD) begin
        if (uartFire) count <= count - 8'd1;
        if (beatFire) begin
          dataReg  <= ipTxStream.Data;
          dataFull <= 1'b1;
          eopSeen  <= ipTxStream.EoP;
        end else if (uartFire) begin
          dataFull <= 1'b0;
        end
      end
    end
  end

`ifdef PACKET_CHECKSUM_EN
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      sumReg <= 8'h00;
    end else if (state == IDLE && beatFire && ipTxStream.SoP) begin
      sumReg <= ipTxStream.Destination + ipTxStream.Source + ipTxStream.Length;
    end else if (state == PAYLOAD && uartFire) begin
      sumReg <= sumReg + opUartData;
    end
  end
`endif

endmodule

// File: tb/tb_packet_tx_framer.sv
// tb/tb_packet_tx_framer.sv - self-checking bench for packet_tx_framer
module tb_packet_tx_framer;
  import packet_tx_framer_pkg::*;

  localparam logic [7:0] SYNC = 8'h55;
  localparam int BUDGET = 4000;

  logic       ipClk = 1'b0;
  logic       ipReset = 1'b1;
  logic       ipUartReady = 1'b0;
  logic       opTxReady;
  logic       opUartValid;
  logic [7:0] opUartData;
  UART_PACKET ipTxStream = '0;

  int errors = 0;
  int checks = 0;
  UART_PACKET stimQ[$];
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];

  typedef struct {
    logic [7:0] len;
    int         nData;
    logic [7:0] data[5];
    int         eopIdx;
    int         readyMode;
    int         nExp;
    logic [7:0] expBytes[8];
  } vecT;
  vecT vecs[6];

  packet_tx_framer #(.SYNC_BYTE(SYNC)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipTxStream(ipTxStream), .opTxReady(opTxReady),
    .opUartData(opUartData), .opUartValid(opUartValid), .ipUartReady(ipUartReady)
  );

  always #5 ipClk = ~ipClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic UART_PACKET mkBeat(input logic [7:0] dst, input logic [7:0] src,
                                        input logic [7:0] len, input logic [7:0] data,
                                        input logic sop, input logic eop);
    UART_PACKET b;
    b.Destination = dst; b.Source = src; b.Length = len; b.Data = data;
    b.SoP = sop; b.EoP = eop; b.Valid = 1'b1;
    return b;
  endfunction

  // Reference: walk the beat list as frames, independent of any cycle timing.
  task automatic buildExpected();
    int i = 0;
    int n;
    logic eop;
    UART_PACKET b;
    expQ.delete();
    while (i < stimQ.size()) begin
      b = stimQ[i];
      i++;
      if (!b.SoP) continue;
      expQ.push_back(SYNC);
      expQ.push_back(b.Destination);
      expQ.push_back(b.Source);
      expQ.push_back(b.Length);
      n = b.Length;
      eop = b.EoP;
      if (n > 0) begin expQ.push_back(b.Data); n--; end
      while (n > 0 && !eop && i < stimQ.size()) begin
        expQ.push_back(stimQ[i].Data);
        eop = stimQ[i].EoP;
        i++;
        n--;
      end
      for (; n > 0; n--) expQ.push_back(8'h00);
      while (!eop && i < stimQ.size()) begin eop = stimQ[i].EoP; i++; end
    end
  endtask

  task automatic runStream(input string tag, input int readyMode, input int bubbleMode, input int stopAfter);
    int cycles = 0;
    int idle = 0;
    logic prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    UART_PACKET cur;
    gotQ.delete();
    while (cycles < BUDGET && idle < 8) begin
      @(negedge ipClk);
      cur = '0;
      if (stimQ.size() > 0 && (bubbleMode == 0 || $urandom_range(3) != 0)) cur = stimQ[0];
      ipTxStream = cur;
      case (readyMode)
        0:       ipUartReady = 1'b1;
        1:       ipUartReady = ((cycles % 2) == 0);
        default: ipUartReady = 1'($urandom_range(1));
      endcase
      #1;
      if (prevStall) begin
        check({tag, " stall valid"}, 32'(opUartValid), 32'd1);
        check({tag, " stall data"}, 32'(opUartData), 32'(prevData));
      end
      prevStall = opUartValid && !ipUartReady;
      prevData = opUartData;
      if (opUartValid && ipUartReady) gotQ.push_back(opUartData);
      if (cur.Valid && opTxReady) void'(stimQ.pop_front());
      cycles++;
      if (stopAfter >= 0 && gotQ.size() == stopAfter) begin
        @(posedge ipClk);
        return;
      end
      if (stimQ.size() == 0 && gotQ.size() >= expQ.size()) idle++;
    end
    ipTxStream = '0;
    if (cycles >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes, expected %0d", tag, gotQ.size(), expQ.size());
    end
  endtask

  task automatic compareStream(input string tag);
    check({tag, " count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(gotQ[i]), 32'(expQ[i]));
  endtask

  task automatic loadVec(input int v);
    stimQ.delete();
    expQ.delete();
    for (int j = 0; j < vecs[v].nData; j++)
      stimQ.push_back(mkBeat(8'h01, 8'h00, vecs[v].len, vecs[v].data[j], j == 0, j == vecs[v].eopIdx));
    for (int j = 0; j < vecs[v].nExp; j++) expQ.push_back(vecs[v].expBytes[j]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd4, 4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 3, 0, 8,
                '{8'h55, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[1] = '{8'd4, 4, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 3, 1, 8,
                '{8'h55, 8'h01, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[2] = '{8'd4, 2, '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 1, 0, 8,
                '{8'h55, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h00, 8'h00}};
    vecs[3] = '{8'd2, 5, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 4, 0, 6,
                '{8'h55, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00}};
    vecs[4] = '{8'd0, 1, '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 4,
                '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[5] = '{8'd3, 3, '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00}, 2, 2, 7,
                '{8'h55, 8'h01, 8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'h00}};

    repeat (3) @(negedge ipClk);
    check("reset ready", 32'(opTxReady), 32'd0);
    check("reset valid", 32'(opUartValid), 32'd0);
    check("reset data", 32'(opUartData), 32'd0);
    ipReset = 1'b0;
    #1 check("release ready before edge", 32'(opTxReady), 32'd0);
    @(posedge ipClk);
    #1 check("ready after first edge", 32'(opTxReady), 32'd1);

    for (int v = 0; v < 6; v++) begin
      loadVec(v);
      runStream($sformatf("vec%0d", v), vecs[v].readyMode, 0, -1);
      compareStream($sformatf("vec%0d", v));
      @(negedge ipClk);
      check($sformatf("vec%0d idle ready", v), 32'(opTxReady), 32'd1);
    end

    stimQ.delete();
    expQ.delete();
    stimQ.push_back(mkBeat(8'h01, 8'h00, 8'h04, 8'h77, 1'b0, 1'b1));
    runStream("nonsop", 0, 0, -1);
    check("nonsop consumed", stimQ.size(), 0);
    compareStream("nonsop");

    loadVec(0);
    runStream("rst", 0, 0, 2);
    #2 ipReset = 1'b1;
    #1;
    check("midframe reset valid", 32'(opUartValid), 32'd0);
    check("midframe reset ready", 32'(opTxReady), 32'd0);
    ipTxStream = '0;
    repeat (2) @(negedge ipClk);
    ipReset = 1'b0;
    loadVec(0);
    runStream("after rst", 0, 0, -1);
    compareStream("after rst");

    for (int r = 0; r < 12; r++) begin
      logic [7:0] dst, src, len;
      int nb;
      stimQ.delete();
      for (int f = 0; f < 4; f++) begin
        if ($urandom_range(2) == 0)
          stimQ.push_back(mkBeat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                                 1'($urandom_range(1))));
        dst = 8'($urandom);
        src = 8'($urandom);
        len = 8'($urandom_range(6));
        nb = $urandom_range(1, 8);
        for (int j = 0; j < nb; j++)
          stimQ.push_back(mkBeat(dst, src, len, 8'($urandom),
                                 (j == 0) ? 1'b1 : ($urandom_range(7) == 0), j == nb - 1));
      end
      buildExpected();
      runStream($sformatf("rand%0d", r), 2, 1, -1);
      compareStream($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
